sa_cache_ctrl: RTL and testbench

Parametrised 2-way set-associative, write-through, no-write-allocate cache controller with a single request port and a pipelined-memory fill interface. One instance serves the instruction side and a second serves the data side. Each instance owns its tag/valid/LRU state, data array and fill sequencer. It generalises set count, block size and data width, adds true per-set LRU replacement and word-accurate fill tracking via memory return-valid, and adds a defined reset-mid-fill behaviour.

---
 rtl/sa_cache_pkg.sv | 23 ++
 rtl/cache_fill_seq.sv | 81 ++++++++
 rtl/sa_cache_ctrl.sv | 127 ++++++++++++
 tb/tb_sa_cache_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_pkg.sv
// rtl/sa_cache_pkg.sv - shared types and address-field width helpers for sa_cache_ctrl
package sa_cache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WAIT} fill_state_t;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int word_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int data_w, input int sets,
                                 input int block_words);
        return addr_w - off_w(data_w) - word_w(block_words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/cache_fill_seq.sv
// rtl/cache_fill_seq.sv - block fill sequencer: issues word reads, tracks in-order returns
module cache_fill_seq
    import sa_cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [tag_w(ADDR_W, DATA_W, SETS, BLOCK_WORDS)+idx_w(SETS)-1:0] miss_blk,
    input  logic                                              victim,
    input  logic                                              mem_rvalid,
    output logic                                              idle,
    output logic                                              issue_en,
    output logic [ADDR_W-1:0]                                 issue_addr,
    output logic                                              fill_we,
    output logic                                              fill_done,
    output logic                                              fill_way,
    output logic [tag_w(ADDR_W, DATA_W, SETS, BLOCK_WORDS)+idx_w(SETS)-1:0] fill_blk,
    output logic [word_w(BLOCK_WORDS)-1:0]                    fill_word
);

    localparam int OFF_W  = off_w(DATA_W);
    localparam int WORD_W = word_w(BLOCK_WORDS);
    localparam logic [WORD_W-1:0] LAST = WORD_W'(BLOCK_WORDS - 1);

    fill_state_t       state, state_next;
    logic [WORD_W-1:0] issue_cnt, ret_cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Issue and return counters run independently so returns may overlap issues
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            fill_blk  <= '0;
            fill_way  <= 1'b0;
        end else if (start) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            fill_blk  <= miss_blk;
            fill_way  <= victim;
        end else begin
            if (issue_en) issue_cnt <= issue_cnt + 1'b1;
            if (fill_we)  ret_cnt   <= ret_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        idle       = 1'b0;
        issue_en   = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (start) state_next = FILL;
            end
            FILL: begin
                issue_en = 1'b1;
                fill_we  = mem_rvalid;
                if (issue_cnt == LAST) state_next = WAIT;
            end
            WAIT: fill_we = mem_rvalid;
            default: state_next = IDLE;
        endcase
        fill_done = fill_we && (ret_cnt == LAST);
        if (fill_done) state_next = IDLE;
    end

    assign fill_word  = ret_cnt;
    assign issue_addr = ADDR_W'({fill_blk, issue_cnt}) << OFF_W;

endmodule

// File: rtl/sa_cache_ctrl.sv
// rtl/sa_cache_ctrl.sv - 2-way set-associative write-through, no-write-allocate cache controller
module sa_cache_ctrl
    import sa_cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int OFF_W  = off_w(DATA_W);
    localparam int WORD_W = word_w(BLOCK_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, DATA_W, SETS, BLOCK_WORDS);
    localparam int BLK_W  = TAG_W + IDX_W;

    logic [TAG_W-1:0]  tag_arr  [2][SETS];
    logic [DATA_W-1:0] data_arr [2][SETS*BLOCK_WORDS];
    logic [SETS-1:0]   valid_arr [2];
    logic [SETS-1:0]   lru;

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              fsm_idle, active, hit0, hit1, hit, hit_way;
    logic              read_hit, write_hit, read_miss, victim;

    logic              issue_en, fill_we, fill_done, fill_way;
    logic [ADDR_W-1:0] issue_addr;
    logic [BLK_W-1:0]  fill_blk;
    logic [WORD_W-1:0] fill_word;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    assign req_word = req_addr[OFF_W +: WORD_W];
    assign req_idx  = req_addr[OFF_W+WORD_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = fill_blk[IDX_W-1:0];
    assign fill_tag = fill_blk[BLK_W-1 -: TAG_W];

    // Lookups only happen while the sequencer is idle and reset is released
    assign active    = req_valid && !rst && fsm_idle;
    assign hit0      = valid_arr[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
    assign hit1      = valid_arr[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
    assign hit       = active && (hit0 || hit1);
    assign hit_way   = !hit0;
    assign read_hit  = hit && !req_we;
    assign write_hit = hit && req_we;
    assign read_miss = active && !req_we && !(hit0 || hit1);
    assign victim    = !valid_arr[0][req_idx] ? 1'b0 :
                       !valid_arr[1][req_idx] ? 1'b1 : lru[req_idx];

    assign stall = read_miss || !fsm_idle;
    assign rdata = read_hit ? data_arr[hit_way][{req_idx, req_word}] : '0;

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (issue_en) begin
            mem_en   = 1'b1;
            mem_addr = issue_addr;
        end else if (active && req_we) begin
            mem_en = 1'b1;
            mem_wr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_arr[0] <= '0;
            valid_arr[1] <= '0;
            lru          <= '0;
        end else begin
            if (hit) lru[req_idx] <= !hit_way;
            if (fill_done) begin
                valid_arr[fill_way][fill_idx] <= 1'b1;
                lru[fill_idx]                 <= !fill_way;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_hit) data_arr[hit_way][{req_idx, req_word}] <= req_wdata;
        if (fill_we)   data_arr[fill_way][{fill_idx, fill_word}] <= mem_rdata;
        if (fill_done) tag_arr[fill_way][fill_idx] <= fill_tag;
    end

    cache_fill_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SETS       (SETS),
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_fill_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (read_miss),
        .miss_blk  (req_addr[ADDR_W-1 -: BLK_W]),
        .victim    (victim),
        .mem_rvalid(mem_rvalid),
        .idle      (fsm_idle),
        .issue_en  (issue_en),
        .issue_addr(issue_addr),
        .fill_we   (fill_we),
        .fill_done (fill_done),
        .fill_way  (fill_way),
        .fill_blk  (fill_blk),
        .fill_word (fill_word)
    );

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb/tb_sa_cache_ctrl.sv - randomized self-checking bench for sa_cache_ctrl against an LRU block model
module tb_sa_cache_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_we, a_stall, a_mem_en, a_mem_wr, a_mem_rvalid;
    logic [15:0] a_req_addr, a_req_wdata, a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_req_valid, b_req_we, b_stall, b_mem_en, b_mem_wr, b_mem_rvalid;
    logic [15:0] b_req_addr, b_mem_addr;
    logic [31:0] b_req_wdata, b_rdata, b_mem_wdata, b_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    sa_cache_ctrl dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rdata(a_rdata), .stall(a_stall),
        .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_rvalid(a_mem_rvalid)
    );

    sa_cache_ctrl #(.ADDR_W(16), .DATA_W(32), .SETS(16), .BLOCK_WORDS(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rdata(b_rdata), .stall(b_stall),
        .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_rvalid(b_mem_rvalid)
    );

    // Backing memories: hashed default contents plus a sparse record of writes
    logic [15:0] wmem_a [int];

    function automatic logic [15:0] mem_a_val(input logic [15:0] addr);
        int k = int'(addr >> 1);
        if (wmem_a.exists(k)) return wmem_a[k];
        return 16'((k * 40503 + 12345) ^ (k >> 3));
    endfunction

    function automatic logic [31:0] mem_b_val(input logic [15:0] addr);
        int k = int'(addr >> 2);
        return 32'(k * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
    endfunction

    logic [3:0]  a_vpipe = '0;
    logic [15:0] a_dpipe [4];
    always @(posedge clk) begin
        a_vpipe    <= {a_vpipe[2:0], a_mem_en & ~a_mem_wr};
        a_dpipe[0] <= mem_a_val(a_mem_addr);
        for (int i = 1; i < 4; i++) a_dpipe[i] <= a_dpipe[i-1];
        if (a_mem_en && a_mem_wr) wmem_a[int'(a_mem_addr >> 1)] = a_mem_wdata;
    end
    assign a_mem_rvalid = a_vpipe[3];
    assign a_mem_rdata  = a_dpipe[3];

    always @(posedge clk) begin
        b_mem_rvalid <= b_mem_en & ~b_mem_wr;
        b_mem_rdata  <= mem_b_val(b_mem_addr);
    end

    // Reference: per set, resident block numbers in most-recently-used-first order
    int unsigned res_q [64][$];

    function automatic bit model_hit(input logic [15:0] addr);
        int unsigned blk = int'(addr >> 4);
        int s = int'(blk % 64);
        for (int i = 0; i < res_q[s].size(); i++)
            if (res_q[s][i] == blk) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_use(input logic [15:0] addr);
        int unsigned blk = int'(addr >> 4);
        int s = int'(blk % 64);
        for (int i = 0; i < res_q[s].size(); i++)
            if (res_q[s][i] == blk) begin
                res_q[s].delete(i);
                break;
            end
        if (res_q[s].size() == 2) void'(res_q[s].pop_back());
        res_q[s].push_front(blk);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) res_q[s].delete();
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access_a(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        bit hit;
        int stalls, nissue, bad;
        bit rd_nz;
        logic [15:0] base;
        hit  = model_hit(addr);
        base = addr & 16'hFFF0;
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
        stalls = 0; nissue = 0; bad = 0; rd_nz = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (a_mem_en && !a_mem_wr) begin
                if (a_mem_addr != base + 16'(2 * nissue)) bad++;
                nissue++;
            end
            if (!a_stall) break;
            if (a_rdata != 16'h0) rd_nz = 1'b1;
            stalls++;
            @(posedge clk); #1;
        end
        if (we) begin
            check("a_wr_stall", 64'(stalls), 64'd0);
            check("a_wr_strobe", {62'd0, a_mem_en, a_mem_wr}, 64'd3);
            check("a_wr_addr", 64'(a_mem_addr), 64'(addr));
            check("a_wr_data", 64'(a_mem_wdata), 64'(wd));
        end else begin
            check("a_rd_stall", 64'(stalls), hit ? 64'd0 : 64'd13);
            check("a_rd_issues", 64'(nissue), hit ? 64'd0 : 64'd8);
            check("a_rd_fill_addr", 64'(bad), 64'd0);
            check("a_rd_zero_in_stall", 64'(rd_nz), 64'd0);
            check("a_rd_data", 64'(a_rdata), 64'(mem_a_val(addr)));
        end
        if (hit || !we) model_use(addr);
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        check("a_idle_quiet", {62'd0, a_stall, a_mem_en}, 64'd0);
    endtask

    task automatic access_b(input logic [15:0] addr, input bit hit);
        int stalls, nissue, bad;
        logic [15:0] base;
        base = addr & 16'hFFF0;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = addr;
        stalls = 0; nissue = 0; bad = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (b_mem_en && !b_mem_wr) begin
                if (b_mem_addr != base + 16'(4 * nissue)) bad++;
                nissue++;
            end
            if (!b_stall) break;
            stalls++;
            @(posedge clk); #1;
        end
        check("b_rd_stall", 64'(stalls), hit ? 64'd0 : 64'd6);
        check("b_rd_issues", 64'(nissue), hit ? 64'd0 : 64'd4);
        check("b_rd_fill_addr", 64'(bad), 64'd0);
        check("b_rd_data", 64'(b_rdata), 64'(mem_b_val(addr)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_outputs", {a_rdata, 13'd0, a_stall, a_mem_en, a_mem_wr}, 64'd0);
        check("rst_b_outputs", {b_rdata, 29'd0, b_stall, b_mem_en, b_mem_wr}, 64'd0);

        access_b(16'h0108, 1'b0);
        access_b(16'h0100, 1'b1);
        access_b(16'h0104, 1'b1);
        access_b(16'h010C, 1'b1);
        @(posedge clk); #1 b_req_valid = 1'b0;

        access_a(1'b0, 16'h1234, 16'h0);
        access_a(1'b0, 16'h1236, 16'h0);
        access_a(1'b0, 16'h0010, 16'h0);
        access_a(1'b0, 16'h0410, 16'h0);
        access_a(1'b0, 16'h0010, 16'h0);
        access_a(1'b0, 16'h0810, 16'h0);
        access_a(1'b0, 16'h0010, 16'h0);
        access_a(1'b0, 16'h0410, 16'h0);
        access_a(1'b1, 16'h1234, 16'hBEEF);
        access_a(1'b0, 16'h1234, 16'h0);
        access_a(1'b1, 16'h2000, 16'h5A5A);
        access_a(1'b0, 16'h2000, 16'h0);
        idle_a();

        // Reset in the middle of a block fill
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h3456;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; a_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midfill_rst_quiet", {62'd0, a_stall, a_mem_en}, 64'd0);
        model_reset();
        repeat (6) idle_a();
        access_a(1'b0, 16'h3456, 16'h0);
        access_a(1'b0, 16'h1234, 16'h0);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] addr;
            addr = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4)
                       | ($urandom_range(0, 7) << 1));
            if ($urandom_range(0, 9) < 3) access_a(1'b1, addr, 16'($urandom));
            else                          access_a(1'b0, addr, 16'h0);
            if ($urandom_range(0, 9) == 0) idle_a();
        end
        idle_a();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
